// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with programmable limit, load and clear.
// Define BCD_CNT_SATURATE_EN to saturate at the boundaries instead of wrapping.
module bcd_updown_counter #(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                count_en,
  input  logic                up_dn,
  input  logic [4*DIGITS-1:0] limit,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                wrap_pulse,
  output logic                at_limit
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] lim_s;
  logic [W-1:0] ld_s;
  logic [W-1:0] inc_v;
  logic [W-1:0] dec_v;

  always_comb begin
    lim_s = '0;
    ld_s  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      lim_s[4*i+:4] = (limit[4*i+:4] > 4'd9)
                    ? 4'd9 : limit[4*i+:4];
      ld_s[4*i+:4]  = (load_val[4*i+:4] > 4'd9)
                    ? 4'd9 : load_val[4*i+:4];
    end
  end

  // Ripple carry through the digits; only used below the limit.
  always_comb begin
    logic cy;
    cy    = 1'b1;
    inc_v = bcd_out;
    for (int i = 0; i < DIGITS; i++) begin
      if (cy) begin
        if (bcd_out[4*i+:4] == 4'd9) begin
          inc_v[4*i+:4] = 4'd0;
        end else begin
          inc_v[4*i+:4] = bcd_out[4*i+:4] + 4'd1;
          cy = 1'b0;
        end
      end
    end
  end

  always_comb begin
    logic bw;
    bw    = 1'b1;
    dec_v = bcd_out;
    for (int i = 0; i < DIGITS; i++) begin
      if (bw) begin
        if (bcd_out[4*i+:4] == 4'd0) begin
          dec_v[4*i+:4] = 4'd9;
        end else begin
          dec_v[4*i+:4] = bcd_out[4*i+:4] - 4'd1;
          bw = 1'b0;
        end
      end
    end
  end

  assign at_limit = (bcd_out == lim_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_out    <= '0;
      wrap_pulse <= 1'b0;
    end else if (clr) begin
      bcd_out    <= '0;
      wrap_pulse <= 1'b0;
    end else if (load) begin
      bcd_out    <= ld_s;
      wrap_pulse <= 1'b0;
    end else if (count_en) begin
      if (up_dn) begin
        if (bcd_out >= lim_s) begin
`ifdef BCD_CNT_SATURATE_EN
          bcd_out <= lim_s;
`else
          bcd_out <= '0;
`endif
          wrap_pulse <= 1'b1;
        end else begin
          bcd_out    <= inc_v;
          wrap_pulse <= 1'b0;
        end
      end else begin
        if (bcd_out == '0) begin
`ifdef BCD_CNT_SATURATE_EN
          bcd_out <= '0;
`else
          bcd_out <= lim_s;
`endif
          wrap_pulse <= 1'b1;
        end else begin
          bcd_out    <= dec_v;
          wrap_pulse <= 1'b0;
        end
      end
    end else begin
      wrap_pulse <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter (2- and 4-digit instances).
// Expectations follow BCD_CNT_SATURATE_EN when it is defined.
module tb_bcd_updown_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr, load, count_en, up_dn;
  logic [7:0]  load_val, limit, bcd_out;
  logic        wrap_pulse, at_limit;
  logic        clr4, load4, en4, up4;
  logic [15:0] lv4, lim4, bcd4;
  logic        wrap4, atl4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load),
    .load_val(load_val), .count_en(count_en), .up_dn(up_dn),
    .limit(limit), .bcd_out(bcd_out), .wrap_pulse(wrap_pulse),
    .at_limit(at_limit)
  );

  bcd_updown_counter #(.DIGITS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .clr(clr4), .load(load4),
    .load_val(lv4), .count_en(en4), .up_dn(up4),
    .limit(lim4), .bcd_out(bcd4), .wrap_pulse(wrap4),
    .at_limit(atl4)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    clr = 0; load = 0; count_en = 0;
  endtask

  logic [7:0] ev;
  logic       ew;

  initial begin
    rst_n = 0; clr = 0; load = 0; count_en = 0; up_dn = 1;
    load_val = 8'h00; limit = 8'h99;
    clr4 = 0; load4 = 0; en4 = 0; up4 = 1;
    lv4 = 16'h0; lim4 = 16'h9999;
    #12;
    check("rst_val", bcd_out, 8'h00);
    check("rst_wrap", wrap_pulse, 1'b0);
    check("rst_atl", at_limit, 1'b0);
    @(negedge clk);
    rst_n = 1;

    // 1: full up sweep to 99 and around
    count_en = 1; up_dn = 1;
    for (int k = 1; k <= 100; k++) begin
      cyc();
      ev = 8'(((k % 100) / 10) << 4 | (k % 10));
      ew = (k == 100);
`ifdef BCD_CNT_SATURATE_EN
      if (k == 100) ev = 8'h99;
`endif
      check("sweep", {wrap_pulse, bcd_out}, {ew, ev});
    end

    // 2: limit 59 boundary
    idle(); limit = 8'h59; load = 1; load_val = 8'h58;
    cyc();
    check("ld58", bcd_out, 8'h58);
    load = 0; count_en = 1; up_dn = 1;
    cyc();
    check("up59", {at_limit, wrap_pulse, bcd_out}, {2'b10, 8'h59});
    cyc();
`ifdef BCD_CNT_SATURATE_EN
    check("sat59", {wrap_pulse, bcd_out}, {1'b1, 8'h59});
`else
    check("wrap00", {wrap_pulse, bcd_out}, {1'b1, 8'h00});
`endif

    // idle hold clears wrap
    idle();
    cyc();
`ifdef BCD_CNT_SATURATE_EN
    check("hold", {wrap_pulse, bcd_out}, {1'b0, 8'h59});
`else
    check("hold", {wrap_pulse, bcd_out}, {1'b0, 8'h00});
`endif

    // 3: down through zero with limit 23
    clr = 1;
    cyc();
    check("clr", bcd_out, 8'h00);
    idle(); limit = 8'h23; count_en = 1; up_dn = 0;
    cyc();
`ifdef BCD_CNT_SATURATE_EN
    check("dn0", {wrap_pulse, bcd_out}, {1'b1, 8'h00});
    cyc();
    check("dn0b", {wrap_pulse, bcd_out}, {1'b1, 8'h00});
`else
    check("dnwrap", {wrap_pulse, bcd_out}, {1'b1, 8'h23});
    cyc();
    check("dn22", {wrap_pulse, bcd_out}, {1'b0, 8'h22});
`endif

    // 4: sanitising and priority
    idle(); load = 1; load_val = 8'h7A; count_en = 1; up_dn = 1;
    cyc();
    check("ld7A", {wrap_pulse, bcd_out}, {1'b0, 8'h79});
    clr = 1; load = 1; load_val = 8'h55;
    cyc();
    check("clrld", bcd_out, 8'h00);
    idle(); load = 1; load_val = 8'h80; limit = 8'h59;
    cyc();
    check("ld80", bcd_out, 8'h80);
    load = 0; count_en = 1; up_dn = 0;
    cyc();
    check("dn79", {wrap_pulse, bcd_out}, {1'b0, 8'h79});
    up_dn = 1;
    cyc();
`ifdef BCD_CNT_SATURATE_EN
    check("abv", {wrap_pulse, bcd_out}, {1'b1, 8'h59});
`else
    check("abv", {wrap_pulse, bcd_out}, {1'b1, 8'h00});
`endif
    idle(); clr = 1;
    cyc();
    idle(); limit = 8'h5F; count_en = 1; up_dn = 0;
    cyc();
`ifdef BCD_CNT_SATURATE_EN
    check("limsan", {wrap_pulse, bcd_out}, {1'b1, 8'h00});
`else
    check("limsan", {at_limit, wrap_pulse, bcd_out}, {2'b11, 8'h59});
`endif

    // limit 0
    idle(); clr = 1;
    cyc();
    idle(); limit = 8'h00; count_en = 1; up_dn = 1;
    cyc();
    check("lim0up", {at_limit, wrap_pulse, bcd_out}, {2'b11, 8'h00});
    up_dn = 0;
    cyc();
    check("lim0dn", {at_limit, wrap_pulse, bcd_out}, {2'b11, 8'h00});
    idle();

    // 5: 4-digit carry chain, then async reset
    load4 = 1; lv4 = 16'h0999;
    cyc();
    check("ld0999", bcd4, 16'h0999);
    load4 = 0; en4 = 1; up4 = 1;
    cyc();
    check("c1000", {wrap4, bcd4}, {1'b0, 16'h1000});
    up4 = 0;
    cyc();
    check("b0999", bcd4, 16'h0999);
    en4 = 0; load = 1; load_val = 8'h42; limit = 8'h59;
    cyc();
    check("pre_rst", bcd_out, 8'h42);
    #2 rst_n = 0;
    #1;
    check("arst2", bcd_out, 8'h00);
    check("arst4", bcd4, 16'h0000);
    check("arstw", wrap_pulse, 1'b0);
    @(negedge clk);
    rst_n = 1;
    idle();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
